// File: rtl/me_frame_loader_if.sv
// Pixel stream and result handshake between the frame loader and its neighbours.
// The pixel producer and result consumer use master; the loader uses slave.
interface me_frame_loader_if #(
    parameter int PIX_W = 8
);
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_dist;
    logic [3:0]       res_mx;
    logic [3:0]       res_my;

    modport master (
        output pix_valid, pix_data, res_ready,
        input  pix_ready, res_valid, res_dist, res_mx, res_my
    );

    modport slave (
        input  pix_valid, pix_data, res_ready,
        output pix_ready, res_valid, res_dist, res_mx, res_my
    );
endinterface

// File: rtl/me_frame_loader.sv
// Loads reference block and search window for the motion-estimation engine,
// runs the engine once per frame and hands its best match out on a result port.
module me_frame_loader #(
    parameter int PIX_W   = 8,
    parameter int R_WORDS = 256,
    parameter int S_WORDS = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    me_frame_loader_if.slave bus,
    output logic             start,
    input  logic             completed,
    input  logic [7:0]       BestDist,
    input  logic [3:0]       motionX,
    input  logic [3:0]       motionY,
    input  logic [7:0]       AddressR,
    input  logic [9:0]       AddressS1,
    input  logic [9:0]       AddressS2,
    output logic [PIX_W-1:0] R,
    output logic [PIX_W-1:0] S1,
    output logic [PIX_W-1:0] S2,
    output logic [7:0]       frame_cnt
);
    typedef enum logic [2:0] {
        ST_LOAD_R  = 3'd0,
        ST_LOAD_S  = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RESULT  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [9:0]       wptr_r, wptr_s;
    logic             start_r, start_s;
    logic             pix_ready_r, pix_ready_s;
    logic             res_valid_r, res_valid_s;
    logic [7:0]       res_dist_r, res_dist_s;
    logic [3:0]       res_mx_r, res_mx_s;
    logic [3:0]       res_my_r, res_my_s;
    logic [7:0]       frame_cnt_r, frame_cnt_s;
    logic             accept_s;
    logic             rmem_we_s;
    logic             smem_we_s;

    logic [PIX_W-1:0] rmem_r [R_WORDS];
    logic [PIX_W-1:0] smem_r [S_WORDS];

    // Next-state, write-enable and output-register decode for the load/compute/result sequence.
    always_comb begin
        state_s     = state_r;
        wptr_s      = wptr_r;
        start_s     = start_r;
        pix_ready_s = pix_ready_r;
        res_valid_s = res_valid_r;
        res_dist_s  = res_dist_r;
        res_mx_s    = res_mx_r;
        res_my_s    = res_my_r;
        frame_cnt_s = frame_cnt_r;
        rmem_we_s   = 1'b0;
        smem_we_s   = 1'b0;
        accept_s    = bus.pix_valid && pix_ready_r;
        case (state_r)
            ST_LOAD_R: begin
                if (accept_s) begin
                    rmem_we_s = 1'b1;
                    if (wptr_r == 10'(R_WORDS - 1)) begin
                        wptr_s  = 10'd0;
                        state_s = ST_LOAD_S;
                    end else begin
                        wptr_s = wptr_r + 10'd1;
                    end
                end else begin
                    wptr_s = wptr_r;
                end
            end
            ST_LOAD_S: begin
                if (accept_s) begin
                    smem_we_s = 1'b1;
                    if (wptr_r == 10'(S_WORDS - 1)) begin
                        wptr_s      = 10'd0;
                        start_s     = 1'b1;
                        pix_ready_s = 1'b0;
                        state_s     = ST_COMPUTE;
                    end else begin
                        wptr_s = wptr_r + 10'd1;
                    end
                end else begin
                    wptr_s = wptr_r;
                end
            end
            ST_COMPUTE: begin
                if (completed) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_COMPUTE;
                end
            end
            // One spare cycle so the engine's comparator has registered its last update.
            ST_SETTLE: begin
                res_dist_s  = BestDist;
                res_mx_s    = motionX;
                res_my_s    = motionY;
                start_s     = 1'b0;
                res_valid_s = 1'b1;
                state_s     = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    res_valid_s = 1'b0;
                    frame_cnt_s = frame_cnt_r + 8'd1;
                    pix_ready_s = 1'b1;
                    state_s     = ST_LOAD_R;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            default: begin
                state_s     = ST_LOAD_R;
                wptr_s      = 10'd0;
                start_s     = 1'b0;
                pix_ready_s = 1'b1;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // Control and result registers; reset drops start immediately so the engine restarts cleanly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_LOAD_R;
            wptr_r      <= 10'd0;
            start_r     <= 1'b0;
            pix_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            res_dist_r  <= 8'd0;
            res_mx_r    <= 4'd0;
            res_my_r    <= 4'd0;
            frame_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            wptr_r      <= wptr_s;
            start_r     <= start_s;
            pix_ready_r <= pix_ready_s;
            res_valid_r <= res_valid_s;
            res_dist_r  <= res_dist_s;
            res_mx_r    <= res_mx_s;
            res_my_r    <= res_my_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    // Reference block storage; deliberately not reset so contents survive reset_n.
    always_ff @(posedge clock) begin
        if (rmem_we_s) begin
            rmem_r[wptr_r[7:0]] <= bus.pix_data;
        end
    end

    // Search window storage; deliberately not reset so contents survive reset_n.
    always_ff @(posedge clock) begin
        if (smem_we_s) begin
            smem_r[wptr_r] <= bus.pix_data;
        end
    end

    assign R             = rmem_r[AddressR];
    assign S1            = smem_r[AddressS1];
    assign S2            = smem_r[AddressS2];
    assign start         = start_r;
    assign frame_cnt     = frame_cnt_r;
    assign bus.pix_ready = pix_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_dist  = res_dist_r;
    assign bus.res_mx    = res_mx_r;
    assign bus.res_my    = res_my_r;
endmodule

// File: tb/tb_me_frame_loader.sv
// Self-checking bench for me_frame_loader: behavioural engine stand-in plus
// array models of the two memories driven by randomized pixel streams.
module tb_me_frame_loader;
    localparam int ENG_LAT = 4111;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       completed;
    logic [7:0] BestDist;
    logic [3:0] motionX;
    logic [3:0] motionY;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;
    logic [7:0] frame_cnt;

    me_frame_loader_if #(.PIX_W(8)) bus ();

    me_frame_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .start     (start),
        .completed (completed),
        .BestDist  (BestDist),
        .motionX   (motionX),
        .motionY   (motionY),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .frame_cnt (frame_cnt)
    );

    int         n_pass = 0;
    int         n_checks = 0;
    int         eng_cnt = 0;
    logic [7:0] mdl_r [256];
    logic [7:0] mdl_s [1024];
    logic [7:0] cap_dist;
    logic [3:0] cap_mx;
    logic [3:0] cap_my;
    int         lat;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Engine stand-in: counts while start is high, completes after a fixed sweep length.
    always @(posedge clock) begin
        if (!start) eng_cnt <= 0;
        else        eng_cnt <= eng_cnt + 1;
    end
    assign completed = start && (eng_cnt >= ENG_LAT);

    // Engine best-match outputs wander every cycle so the capture edge matters.
    always @(negedge clock) begin
        BestDist = 8'($urandom);
        motionX  = 4'($urandom);
        motionY  = 4'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Streams all 1280 model pixels; valid asserted with probability valid_pct.
    task automatic load_frame(input int valid_pct);
        int k;
        int cyc;
        int bad;
        k = 0; cyc = 0; bad = 0;
        while (k < 1280 && cyc < 10000) begin
            @(negedge clock);
            if (int'($urandom_range(99)) < valid_pct) begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = (k < 256) ? mdl_r[k] : mdl_s[k - 256];
            end else begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = 8'($urandom);
            end
            if (bus.pix_ready !== 1'b1 || start !== 1'b0) bad++;
            @(posedge clock);
            if (bus.pix_valid) k++;
            cyc++;
        end
        #1;
        check("load_accepts", k, 1280);
        check("load_ready_and_start_low", bad, 0);
        check("start_at_last_accept", start, 1'b1);
        check("pix_ready_low_in_compute", bus.pix_ready, 1'b0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'hEE;
    endtask

    // Counts edges from the last accept until res_valid, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 6000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("start_low_with_result", start, 1'b0);
        check("res_dist_capture", bus.res_dist, BestDist);
        check("res_mx_capture", bus.res_mx, motionX);
        check("res_my_capture", bus.res_my, motionY);
        cap_dist = bus.res_dist;
        cap_mx   = bus.res_mx;
        cap_my   = bus.res_my;
    endtask

    task automatic readback(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            AddressR  = 8'($urandom);
            AddressS1 = 10'($urandom);
            AddressS2 = 10'($urandom);
            #1;
            if (R !== mdl_r[AddressR] || S1 !== mdl_s[AddressS1] || S2 !== mdl_s[AddressS2]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic stall_result(input int n);
        int bad;
        bad = 0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_dist !== cap_dist ||
                bus.res_mx !== cap_mx || bus.res_my !== cap_my) bad++;
        end
        check("result_stall_stable", bad, 0);
    endtask

    task automatic handshake(input logic [7:0] exp_cnt);
        @(negedge clock);
        bus.pix_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.res_ready = 1'b0;
        check("res_valid_cleared", bus.res_valid, 1'b0);
        check("frame_cnt_incr", frame_cnt, exp_cnt);
        check("pix_ready_after_handshake", bus.pix_ready, 1'b1);
    endtask

    initial begin
        int bad;
        reset_n       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'd0;
        bus.res_ready = 1'b0;
        AddressR      = 8'd0;
        AddressS1     = 10'd0;
        AddressS2     = 10'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_start", start, 1'b0);
        check("reset_res_valid", bus.res_valid, 1'b0);
        check("reset_pix_ready", bus.pix_ready, 1'b1);
        check("reset_frame_cnt", frame_cnt, 8'd0);
        check("reset_res_fields", {bus.res_dist, bus.res_mx, bus.res_my}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Frame 1: address pattern, full-rate stream, long result stall.
        for (int a = 0; a < 256; a++)  mdl_r[a] = 8'(a);
        for (int a = 0; a < 1024; a++) mdl_s[a] = 8'(a) ^ 8'(a >> 8);
        load_frame(100);
        wait_result(lat);
        check("latency_f1", lat, 4113);
        AddressR  = 8'hA5;
        AddressS1 = 10'h3FF;
        AddressS2 = 10'h100;
        #1;
        check("read_R_A5", R, 8'hA5);
        check("read_S1_3FF", S1, 8'hFC);
        check("read_S2_100", S2, 8'h01);
        stall_result(100);
        handshake(8'd1);

        // Frame 2: flat 0x10 data under 50% stream backpressure.
        for (int a = 0; a < 256; a++)  mdl_r[a] = 8'h10;
        for (int a = 0; a < 1024; a++) mdl_s[a] = 8'h10;
        load_frame(50);
        wait_result(lat);
        check("latency_f2", lat, 4113);
        readback("readback_f2", 8);
        handshake(8'd2);

        // Frame 3: random data, then reset part way through the engine run.
        for (int a = 0; a < 256; a++)  mdl_r[a] = 8'($urandom);
        for (int a = 0; a < 1024; a++) mdl_s[a] = 8'($urandom);
        load_frame(100);
        repeat (2000) @(posedge clock);
        #1;
        check("compute_still_running", {start, bus.res_valid}, 2'b10);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_start", start, 1'b0);
        check("async_reset_pix_ready", bus.pix_ready, 1'b1);
        check("async_reset_res_valid", bus.res_valid, 1'b0);
        check("async_reset_frame_cnt", frame_cnt, 8'd0);
        bus.pix_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4200; i++) begin
            @(posedge clock);
            #1;
            if (bus.res_valid !== 1'b0 || start !== 1'b0 || bus.pix_ready !== 1'b1) bad++;
        end
        check("no_result_after_reset", bad, 0);
        readback("old_contents_after_reset", 8);
        @(negedge clock);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'h5A;
        @(posedge clock);
        #1;
        bus.pix_valid = 1'b0;
        mdl_r[0] = 8'h5A;
        AddressR = 8'd0;
        #1;
        check("first_pixel_to_R0", R, 8'h5A);
        AddressR = 8'd1;
        #1;
        check("R1_untouched", R, mdl_r[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
